// File: rtl/turbo_deinterleaver_fsm.sv
// LTE QPP turbo deinterleaver: writes each incoming bit to pi(i) of a
// ping-pong bank, then drains the bank sequentially to restore bit order.
module turbo_deinterleaver_fsm #(
    parameter int K_SMALL  = 1056,
    parameter int F1_SMALL = 17,
    parameter int F2_SMALL = 66,
    parameter int K_LARGE  = 6144,
    parameter int F1_LARGE = 263,
    parameter int F2_LARGE = 480,
    parameter int AW       = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic block_size,
    input  logic in_start,
    input  logic in_valid,
    input  logic in_data,
    output logic in_ready,
    output logic out_valid,
    output logic out_data,
    output logic out_start,
    output logic out_end,
    input  logic out_ready,
    output logic done,
    output logic overflow_err
);

    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_FILL  = 1'b1;
    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_DRAIN = 1'b1;

    // Per-size constants: pi(1), g(1) = pi(2)-pi(1), and the g increment
    localparam logic [AW-1:0] KS  = AW'(K_SMALL);
    localparam logic [AW-1:0] P1S = AW'((F1_SMALL + F2_SMALL) % K_SMALL);
    localparam logic [AW-1:0] G1S = AW'((F1_SMALL + 3 * F2_SMALL) % K_SMALL);
    localparam logic [AW-1:0] D2S = AW'((2 * F2_SMALL) % K_SMALL);
    localparam logic [AW-1:0] KL  = AW'(K_LARGE);
    localparam logic [AW-1:0] P1L = AW'((F1_LARGE + F2_LARGE) % K_LARGE);
    localparam logic [AW-1:0] G1L = AW'((F1_LARGE + 3 * F2_LARGE) % K_LARGE);
    localparam logic [AW-1:0] D2L = AW'((2 * F2_LARGE) % K_LARGE);

    logic          mem0 [K_LARGE];
    logic          mem1 [K_LARGE];

    logic [0:0]    w_state;
    logic          wbank;
    logic [1:0]    full;
    logic [1:0]    klarge;
    logic [AW-1:0] k_w;
    logic [AW-1:0] pi;
    logic [AW-1:0] g;
    logic [AW-1:0] d2;
    logic [AW-1:0] i_cnt;

    logic [0:0]    r_state;
    logic          rbank;
    logic [AW-1:0] j;
    logic [AW-1:0] rk;

    logic          accept;
    logic          wr_en;
    logic          last_wr;
    logic          last_rd;
    logic          adv;
    logic [AW-1:0] wr_addr;
    logic [AW:0]   pi_sum;
    logic [AW:0]   g_sum;
    logic [AW-1:0] pi_nxt;
    logic [AW-1:0] g_nxt;

    // Handshake and address recurrences; each mod is one conditional subtract
    always_comb begin
        in_ready = ~reset & ~full[wbank];
        accept   = in_valid & in_ready;
        wr_en    = accept & (in_start | (w_state == W_FILL));
        wr_addr  = in_start ? '0 : pi;
        last_wr  = accept & ~in_start & (w_state == W_FILL)
                 & (i_cnt == k_w - AW'(1));
        pi_sum   = {1'b0, pi} + {1'b0, g};
        g_sum    = {1'b0, g} + {1'b0, d2};
        pi_nxt   = (pi_sum >= {1'b0, k_w}) ? AW'(pi_sum - {1'b0, k_w})
                                           : pi_sum[AW-1:0];
        g_nxt    = (g_sum >= {1'b0, k_w}) ? AW'(g_sum - {1'b0, k_w})
                                          : g_sum[AW-1:0];
        adv      = ~out_valid | out_ready;
        last_rd  = (r_state == R_DRAIN) & out_valid & out_ready & out_end;
    end

    // Bank storage; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wbank) mem1[wr_addr] <= in_data;
            else       mem0[wr_addr] <= in_data;
        end
    end

    // Writer FSM: QPP address generation and block restart on early in_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state      <= W_IDLE;
            wbank        <= 1'b0;
            klarge       <= 2'b00;
            k_w          <= '0;
            pi           <= '0;
            g            <= '0;
            d2           <= '0;
            i_cnt        <= '0;
            overflow_err <= 1'b0;
        end else if (accept) begin
            if (in_start) begin
                if (w_state == W_FILL) overflow_err <= 1'b1;
                klarge[wbank] <= block_size;
                k_w     <= block_size ? KL  : KS;
                pi      <= block_size ? P1L : P1S;
                g       <= block_size ? G1L : G1S;
                d2      <= block_size ? D2L : D2S;
                i_cnt   <= AW'(1);
                w_state <= W_FILL;
            end else if (w_state == W_FILL) begin
                pi    <= pi_nxt;
                g     <= g_nxt;
                i_cnt <= i_cnt + AW'(1);
                if (last_wr) begin
                    w_state <= W_IDLE;
                    wbank   <= ~wbank;
                end
            end
        end
    end

    // Bank-full flags: set by the writer, cleared by the reader
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (last_wr && (wbank == b[0]))      full[b] <= 1'b1;
                else if (last_rd && (rbank == b[0])) full[b] <= 1'b0;
            end
        end
    end

    // Reader FSM with a registered output stage that freezes while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            rbank     <= 1'b0;
            j         <= '0;
            rk        <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_start <= 1'b0;
            out_end   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == R_IDLE) begin
                if (full[rbank]) begin
                    j       <= '0;
                    rk      <= klarge[rbank] ? KL : KS;
                    r_state <= R_DRAIN;
                end
            end else if (adv) begin
                if (out_valid && out_end) begin
                    out_valid <= 1'b0;
                    out_start <= 1'b0;
                    out_end   <= 1'b0;
                    rbank     <= ~rbank;
                    done      <= 1'b1;
                    r_state   <= R_IDLE;
                end else if (j != rk) begin
                    out_valid <= 1'b1;
                    out_data  <= rbank ? mem1[j] : mem0[j];
                    out_start <= (j == '0);
                    out_end   <= (j == rk - AW'(1));
                    j         <= j + AW'(1);
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_turbo_deinterleaver_fsm.sv
// Directed bench for turbo_deinterleaver_fsm; expected output order comes
// from the closed-form QPP pi(i) = (f1*i + f2*i*i) mod K.
module tb_turbo_deinterleaver_fsm;

    logic clk = 1'b0;
    logic reset;
    logic block_size;
    logic in_start;
    logic in_valid;
    logic in_data;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_start;
    logic out_end;
    logic out_ready;
    logic done;
    logic overflow_err;

    turbo_deinterleaver_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .block_size   (block_size),
        .in_start     (in_start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_start    (out_start),
        .out_end      (out_end),
        .out_ready    (out_ready),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asrt = 0;
    int n_fail = 0;
    bit blk [3][6144];
    bit ex  [6144];
    bit rx  [6144];
    int rx_cnt, start_cnt, end_cnt, start_pos, end_pos;
    int first_valid, last_acc;
    bit rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill(input int b, input int mode, input int one_at);
        for (int i = 0; i < 6144; i++)
            blk[b][i] = (mode == 1) ? 1'($urandom_range(0, 1))
                                    : (i == one_at);
    endtask

    task automatic build_exp(input int b, input int k);
        longint f1, f2, p;
        f1 = (k == 1056) ? 17 : 263;
        f2 = (k == 1056) ? 66 : 480;
        for (int i = 0; i < k; i++) begin
            p = (f1 * longint'(i) + f2 * longint'(i) * longint'(i))
                % longint'(k);
            ex[int'(p)] = blk[b][i];
        end
    endtask

    task automatic send(input int b, input bit bs, input int n);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 40000) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_start   = (i == 0);
            in_data    = blk[b][i];
            block_size = bs;
            acc        = in_ready;
            if (acc) last_acc = cyc;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
        in_data  = 1'b0;
        chk("send_beats", i, n);
    endtask

    task automatic recv(input int k);
        int guard = 0;
        bit got_end = 1'b0;
        bit prev_stall = 1'b0;
        logic [3:0] prev = '0;
        bit rdy;
        rx_cnt = 0; start_cnt = 0; end_cnt = 0;
        start_pos = -1; end_pos = -1; first_valid = -1;
        while (!got_end && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall)
                chk("stall_hold", {out_valid, out_data, out_start, out_end},
                    prev);
            rdy = !rand_ready || ($urandom_range(0, 1) == 1);
            out_ready  = rdy;
            prev_stall = out_valid && !rdy;
            prev = {out_valid, out_data, out_start, out_end};
            if (out_valid && rdy) begin
                if (rx_cnt < 6144) rx[rx_cnt] = out_data;
                if (out_start) begin start_cnt++; start_pos = rx_cnt; end
                if (out_end) begin
                    end_cnt++; end_pos = rx_cnt; got_end = 1'b1;
                end
                rx_cnt++;
            end
        end
        chk("recv_end_seen", got_end, 1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("out_count", rx_cnt, k);
        chk("start_cnt", start_cnt, 1);
        chk("start_pos", start_pos, 0);
        chk("end_cnt", end_cnt, 1);
        chk("end_pos", end_pos, k - 1);
    endtask

    task automatic check_data(input string tag, input int k);
        int m = 0;
        for (int i = 0; i < k; i++) if (rx[i] !== ex[i]) m++;
        chk(tag, m, 0);
    endtask

    task automatic count_ones(input int k, output int n);
        n = 0;
        for (int i = 0; i < k; i++) if (rx[i]) n++;
    endtask

    initial begin
        int ones;
        reset = 1'b1; block_size = 1'b0; in_start = 1'b0;
        in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_out_end", out_end, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        // single one at input index 1, K=1056 -> position 83
        fill(0, 0, 1);
        send(0, 1'b0, 1056);
        build_exp(0, 1056);
        recv(1056);
        check_data("t1_data", 1056);
        count_ones(1056, ones);
        chk("t1_ones", ones, 1);
        chk("t1_pos83", rx[83], 1);

        // index 2, K=1056 -> 298
        fill(0, 0, 2);
        send(0, 1'b0, 1056);
        recv(1056);
        chk("t2_pos298", rx[298], 1);
        count_ones(1056, ones);
        chk("t2_ones", ones, 1);

        // index 1, K=6144 -> 743
        fill(1, 0, 1);
        send(1, 1'b1, 6144);
        recv(6144);
        chk("t2_pos743", rx[743], 1);
        count_ones(6144, ones);
        chk("t2_ones_l", ones, 1);

        // random K=6144 block and latency
        fill(0, 1, 0);
        send(0, 1'b1, 6144);
        build_exp(0, 6144);
        recv(6144);
        check_data("t3_data", 6144);
        chk("t3_latency", first_valid - last_acc, 3);

        // three blocks with downstream stalled until both banks are full
        fill(0, 1, 0);
        fill(1, 1, 0);
        fill(2, 1, 0);
        out_ready = 1'b0;
        send(0, 1'b0, 1056);
        send(1, 1'b1, 6144);
        @(negedge clk);
        chk("t4_both_full", in_ready, 0);
        fork
            send(2, 1'b0, 1056);
            begin
                build_exp(0, 1056);
                recv(1056);
                check_data("t4_blk0", 1056);
                build_exp(1, 6144);
                recv(6144);
                check_data("t4_blk1", 6144);
                build_exp(2, 1056);
                recv(1056);
                check_data("t4_blk2", 1056);
            end
        join

        // random backpressure
        rand_ready = 1'b1;
        fill(0, 1, 0);
        send(0, 1'b0, 1056);
        build_exp(0, 1056);
        recv(1056);
        check_data("t5_small", 1056);
        fill(1, 1, 0);
        send(1, 1'b1, 6144);
        build_exp(1, 6144);
        recv(6144);
        check_data("t5_large", 6144);
        rand_ready = 1'b0;

        // in_start reissued mid-block
        chk("t6_ovf_before", overflow_err, 0);
        fill(0, 1, 0);
        send(0, 1'b0, 500);
        send(0, 1'b0, 1056);
        chk("t6_ovf_set", overflow_err, 1);
        build_exp(0, 1056);
        recv(1056);
        check_data("t6_data", 1056);
        chk("t6_ovf_sticky", overflow_err, 1);

        // reset during drain, then a clean block
        fill(0, 1, 0);
        send(0, 1'b0, 1056);
        out_ready = 1'b1;
        repeat (50) @(negedge clk);
        chk("t7_draining", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_data", out_data, 0);
        chk("t7_rst_start", out_start, 0);
        chk("t7_rst_end", out_end, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_ovf", overflow_err, 0);
        chk("t7_rst_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        fill(1, 1, 0);
        send(1, 1'b0, 1056);
        build_exp(1, 1056);
        recv(1056);
        check_data("t7_after", 1056);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
